dht11_responder_emu: RTL and testbench
======================================

// Module: dht11_responder_emu
// PURPOSE
//  Device-side emulator of the DHT11 single-wire protocol: detects the host start pulse on
//  dht11_io, answers with the DHT11 response preamble and a 40-bit frame built from its
//  data inputs. Used for loopback bring-up of dht11_sensor on the board without a real
//  sensor, and as a synthesizable responder in the sensor-reader testbench.
// PARAMETERS
//  CYCLES_PER_US  50     clk cycles per microsecond (50 MHz board clock)
//  START_MIN_US   18000  minimum host low time accepted as a start request
//  RESP_WAIT_US   30     delay after host release before responder pulls low
//  RESP_LOW_US    80     response low phase; RESP_HIGH_US 80 response high phase
//  BIT_LOW_US     50     low lead-in of every bit and of the end-of-frame pulse
//  BIT0_HIGH_US   26     high time encoding '0';  BIT1_HIGH_US 70 high time encoding '1'
// PORTS
//  clk          in     1  system clock
//  rst          in     1  synchronous reset, active-high
//  dht11_io     inout  1  open-drain data line: driven 1'b0 or 1'bz, external pull-up
//  hum_int      in     8  humidity integer byte to transmit
//  hum_dec      in     8  humidity decimal byte
//  temp_int     in     8  temperature integer byte
//  temp_dec     in     8  temperature decimal byte
//  busy         out    1  high from qualified start until line released after frame
//  frame_done   out    1  one-cycle pulse after end-of-frame low pulse completes
//  err          out    1  one-cycle pulse on line contention (frame aborted)
//  state_dbg    out    3  current FSM state encoding
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-frame): line released (z) at next edge, busy=0,
//    frame_done=0, err=0, state_dbg=IDLE(0), counters and shift register cleared.
//  - dht11_io sampled through 2-flop synchronizer; all decisions use synced value (2-cycle lag).
//  - FSM: IDLE(0) -> HOST_LOW(1) -> WAIT(2) -> RESP_LO(3) -> RESP_HI(4) -> BIT_LO(5) ->
//    BIT_HI(6) -> (next bit BIT_LO | after bit 39 END_LO(7)) -> IDLE.
//  - IDLE: synced line 0 -> HOST_LOW, low counter starts at 1.
//  - HOST_LOW: counter saturates at START_MIN_US*CYCLES_PER_US. On line 1: if counter
//    reached threshold -> WAIT, latch 40-bit frame, busy=1; else back to IDLE, no response.
//  - Frame = {hum_int, hum_dec, temp_int, temp_dec, chk}, chk = 8-bit sum of the four bytes
//    mod 256; transmitted MSB first. Inputs changing after latch do not affect the frame.
//  - Drive low in RESP_LO, BIT_LO, END_LO; released in all other states.
//  - Each timed state lasts exactly <param>_US*CYCLES_PER_US clk cycles.
//  - BIT_HI duration selected by current frame bit (BIT0/BIT1_HIGH_US); shift left on exit.
//  - Contention: synced line 0 while in RESP_HI or BIT_HI (after 2-cycle sync grace at
//    state entry) -> err pulse, release, busy=0, IDLE. Host low during WAIT also aborts with err.
//  - END_LO exit: release line, frame_done pulse same cycle as busy falls, -> IDLE.
//  - New start in IDLE accepted the cycle after frame_done; no queuing of requests.
//  - Single down-counter wide enough for START_MIN_US*CYCLES_PER_US ($clog2, 20 bits default).
// STRUCTURE
//  - Shared header dht11_defs.vh: state encodings (3-bit localparams), default timing
//    constants in us, frame width 40; shared with dht11_sensor for consistency.
//  - Sub-module dht11_line_sync: 2-flop synchronizer of dht11_io with falling/rising edge
//    strobes; reused by the reader side.
//  - Tri-state only at top of this module: assign dht11_io = drive_low ? 1'b0 : 1'bz.
// TESTING (CYCLES_PER_US=2, START_MIN_US=100; pull-up on dht11_io in bench)
//  - Host low 250 cyc, release; bytes 0x37,0x00,0x19,0x05 -> 60 cyc wait, 160 low, 160 high,
//    40 bits decode to 0x37 00 19 05 55, frame_done one pulse, busy low after.
//  - Host low 150 cyc (<200) then release -> no drive ever, busy stays 0, state back to IDLE.
//  - Bytes 0xFF,0xFF,0xFF,0xFF -> chk 0xFC; every '1' high = 140 cyc, '0' high = 52 cyc.
//  - Bench pulls line low during bit 10 high phase -> err pulse, line released, busy=0,
//    then fresh valid start yields a full correct frame.
//  - rst asserted mid BIT_LO -> line z next cycle, all outputs at reset values.
//  - Change hum_int after start qualified -> transmitted frame carries latched value.

Source files
------------

// File: rtl/dht11_responder_emu_pkg.sv
// Shared definitions for the DHT11 responder emulator: state encodings, default timing and frame build.
package dht11_responder_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOST_LOW = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RESP_LO  = 3'd3,
        ST_RESP_HI  = 3'd4,
        ST_BIT_LO   = 3'd5,
        ST_BIT_HI   = 3'd6,
        ST_END_LO   = 3'd7
    } state_t;

    localparam int FRAME_BITS       = 40;
    localparam int DEF_CYCLES_PER_US = 50;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_RESP_WAIT_US = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;

    // Checksum is the plain 8-bit wrap-around sum of the four data bytes.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti, input logic [7:0] td);
        logic [7:0] chk;
        chk = hi + hd + ti + td;
        return {hi, hd, ti, td, chk};
    endfunction

endpackage

// File: rtl/dht11_responder_emu_line_sync.sv
// Two-flop synchronizer for the single-wire data line with falling/rising edge strobes.
module dht11_responder_emu_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic line,
    output logic fall,
    output logic rise
);

    logic meta;
    logic prev;

    // Idle level of the line is high (pull-up), so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            line <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            line <= meta;
            prev <= line;
        end
    end

    assign fall = prev & ~line;
    assign rise = ~prev & line;

endmodule

// File: rtl/dht11_responder_emu.sv
// DHT11 device-side emulator: qualifies the host start pulse and answers with preamble plus 40-bit frame.
module dht11_responder_emu
    import dht11_responder_emu_pkg::*;
#(
    parameter int CYCLES_PER_US = DEF_CYCLES_PER_US,
    parameter int START_MIN_US  = DEF_START_MIN_US,
    parameter int RESP_WAIT_US  = DEF_RESP_WAIT_US,
    parameter int RESP_LOW_US   = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US  = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US    = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US  = DEF_BIT1_HIGH_US
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dht11_io,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int START_CYC = START_MIN_US * CYCLES_PER_US;
    localparam int CNT_W     = $clog2(START_CYC + 1);

    localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(RESP_WAIT_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] RLO_LD   = CNT_W'(RESP_LOW_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] RHI_LD   = CNT_W'(RESP_HIGH_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] BLO_LD   = CNT_W'(BIT_LOW_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] BIT0_LD  = CNT_W'(BIT0_HIGH_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] BIT1_LD  = CNT_W'(BIT1_HIGH_US * CYCLES_PER_US - 1);

    logic                  line, line_fall, line_rise;
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [5:0]            bit_idx;
    logic [1:0]            settle;
    logic                  drive_low;
    logic                  contention;

    dht11_responder_emu_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (dht11_io),
        .line (line),
        .fall (line_fall),
        .rise (line_rise)
    );

    assign dht11_io   = drive_low ? 1'b0 : 1'bz;
    assign state_dbg  = state;
    // After releasing, the synced line still shows our own low for two cycles.
    assign contention = (settle == 2'd0) && !line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            settle     <= '0;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (settle != 2'd0)
                settle <= settle - 2'd1;

            case (state)
                ST_IDLE: begin
                    if (line_fall) begin
                        state <= ST_HOST_LOW;
                        cnt   <= START_LD;
                    end
                end
                ST_HOST_LOW: begin
                    if (line_rise) begin
                        if (cnt == '0) begin
                            state   <= ST_WAIT;
                            cnt     <= WAIT_LD;
                            frame   <= build_frame(hum_int, hum_dec, temp_int, temp_dec);
                            bit_idx <= '0;
                            busy    <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!line) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (cnt == '0) begin
                        state     <= ST_RESP_LO;
                        cnt       <= RLO_LD;
                        drive_low <= 1'b1;
                    end
                end
                ST_RESP_LO: begin
                    if (cnt == '0) begin
                        state     <= ST_RESP_HI;
                        cnt       <= RHI_LD;
                        drive_low <= 1'b0;
                        settle    <= 2'd2;
                    end
                end
                ST_RESP_HI, ST_BIT_HI: begin
                    if (contention) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                        settle <= 2'd0;
                    end else if (cnt == '0) begin
                        drive_low <= 1'b1;
                        cnt       <= BLO_LD;
                        if (state == ST_RESP_HI) begin
                            state <= ST_BIT_LO;
                        end else begin
                            frame <= frame << 1;
                            if (bit_idx == 6'(FRAME_BITS - 1)) begin
                                state <= ST_END_LO;
                            end else begin
                                bit_idx <= bit_idx + 6'd1;
                                state   <= ST_BIT_LO;
                            end
                        end
                    end
                end
                ST_BIT_LO: begin
                    if (cnt == '0) begin
                        state     <= ST_BIT_HI;
                        cnt       <= frame[FRAME_BITS-1] ? BIT1_LD : BIT0_LD;
                        drive_low <= 1'b0;
                        settle    <= 2'd2;
                    end
                end
                ST_END_LO: begin
                    if (cnt == '0) begin
                        state      <= ST_IDLE;
                        drive_low  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder_emu.sv
// Self-checking bench for dht11_responder_emu: plays the host, times the line and decodes frames.
module tb_dht11_responder_emu;

    localparam int CPU      = 2;
    localparam int START_US = 100;
    localparam int T_START  = START_US * CPU;
    localparam int T_WAIT   = 30 * CPU;
    localparam int T_RLO    = 80 * CPU;
    localparam int T_RHI    = 80 * CPU;
    localparam int T_BLO    = 50 * CPU;
    localparam int T_B0     = 26 * CPU;
    localparam int T_B1     = 70 * CPU;
    // Host release to responder low: two synchronizer flops plus the registered state update.
    localparam int SYNC_LAG = 3;
    localparam int LIMIT    = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_drive = 1'b0;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
    logic       busy, frame_done, err;
    logic [2:0] state_dbg;
    wire        dht11_io;

    pullup (dht11_io);
    assign dht11_io = host_drive ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_responder_emu #(.CYCLES_PER_US(CPU), .START_MIN_US(START_US)) dut (
        .clk        (clk),
        .rst        (rst),
        .dht11_io   (dht11_io),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          cap_wait, cap_rlo, cap_rhi, cap_end;
    int          cap_lo[40];
    int          cap_hi[40];
    logic [39:0] cap_frame;
    bit          cap_to;

    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d);
        logic [7:0] s;
        s = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
        return {a, b, c, d, s};
    endfunction

    // Number of captured phases whose length differs from the nominal waveform of frame f.
    function automatic int timing_errors(input logic [39:0] f);
        int e = 0;
        if (cap_wait != T_WAIT + SYNC_LAG) e++;
        if (cap_rlo != T_RLO) e++;
        if (cap_rhi != T_RHI) e++;
        for (int i = 0; i < 40; i++) begin
            if (cap_lo[i] != T_BLO) e++;
            if (cap_hi[i] != (f[39-i] ? T_B1 : T_B0)) e++;
        end
        if (cap_end != T_BLO) e++;
        return e;
    endfunction

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (dht11_io === lvl && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) cap_to = 1'b1;
    endtask

    task automatic host_start(input int low_cyc);
        @(negedge clk);
        host_drive = 1'b1;
        repeat (low_cyc) @(negedge clk);
        host_drive = 1'b0;
        #1;
    endtask

    task automatic capture();
        cap_to = 1'b0;
        run_len(1'b1, cap_wait);
        run_len(1'b0, cap_rlo);
        run_len(1'b1, cap_rhi);
        for (int i = 0; i < 40; i++) begin
            run_len(1'b0, cap_lo[i]);
            run_len(1'b1, cap_hi[i]);
            cap_frame = {cap_frame[38:0], cap_hi[i] > (T_B0 + T_B1) / 2};
        end
        run_len(1'b0, cap_end);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if ({busy, frame_done, err, state_dbg, dht11_io} !== 7'b0000001)
            $display("FAIL reset_state: got %b want 0000001", {busy, frame_done, err, state_dbg, dht11_io});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] a, b, c, d, input int low_cyc, input bit mutate);
        logic [39:0] exp;
        logic        busy_mid;
        int          terr;
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
        exp = model_frame(a, b, c, d);
        host_start(low_cyc);
        fork
            capture();
            begin
                repeat (100) @(negedge clk);
                busy_mid = busy;
                if (mutate) hum_int = ~a;
            end
        join
        terr = timing_errors(exp);
        n_checks++;
        if (cap_to) $display("FAIL frame_timeout: got timeout want completed frame");
        else n_pass++;
        n_checks++;
        if (cap_frame !== exp) $display("FAIL frame_value: got %h want %h", cap_frame, exp);
        else n_pass++;
        n_checks++;
        if (terr != 0)
            $display("FAIL frame_timing: got %0d bad phases want 0 (wait %0d rlo %0d rhi %0d end %0d)",
                     terr, cap_wait, cap_rlo, cap_rhi, cap_end);
        else n_pass++;
        n_checks++;
        if (busy_mid !== 1'b1) $display("FAIL busy_mid_frame: got %b want 1", busy_mid);
        else n_pass++;
        n_checks++;
        if ({frame_done, busy} !== 2'b10) $display("FAIL frame_done_pulse: got %b want 10", {frame_done, busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({frame_done, busy, state_dbg} !== 5'b00000)
            $display("FAIL after_frame: got %b want 00000", {frame_done, busy, state_dbg});
        else n_pass++;
    endtask

    task automatic test_all_ones();
        int ones_ok = 0;
        test_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, T_START, 1'b0);
        n_checks++;
        if (cap_frame[7:0] !== 8'hFC) $display("FAIL all_ones_chk: got %h want fc", cap_frame[7:0]);
        else n_pass++;
        for (int i = 0; i < 32; i++) if (cap_hi[i] == T_B1) ones_ok++;
        n_checks++;
        if (ones_ok != 32 || cap_hi[38] != T_B0 || cap_hi[39] != T_B0)
            $display("FAIL all_ones_widths: got %0d ones ok, bit38 %0d bit39 %0d want 32/%0d/%0d",
                     ones_ok, cap_hi[38], cap_hi[39], T_B0, T_B0);
        else n_pass++;
    endtask

    task automatic test_short_start();
        int lens[2] = '{150, T_START - 1};
        for (int k = 0; k < 2; k++) begin
            bit saw_low = 1'b0, saw_busy = 1'b0;
            host_start(lens[k]);
            repeat (400) begin
                @(negedge clk);
                if (dht11_io === 1'b0) saw_low = 1'b1;
                if (busy === 1'b1) saw_busy = 1'b1;
            end
            n_checks++;
            if ({saw_low, saw_busy, state_dbg} !== 5'b00000)
                $display("FAIL short_start_%0d: got low/busy/state %b want 00000", lens[k], {saw_low, saw_busy, state_dbg});
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        int n, n_err;
        // Host yanks the line during the response wait.
        host_start(T_START + 50);
        repeat (10) @(negedge clk);
        host_drive = 1'b1;
        n_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (err === 1'b1) n_err++;
            if (i == 4) host_drive = 1'b0;
        end
        n_checks++;
        if (n_err != 1 || busy !== 1'b0 || state_dbg !== 3'd0)
            $display("FAIL wait_abort: got err pulses %0d busy %b state %0d want 1 0 0", n_err, busy, state_dbg);
        else n_pass++;
        // Host yanks the line during the high phase of bit 10.
        hum_int = 8'($urandom); hum_dec = 8'($urandom);
        host_start(T_START + 50);
        cap_to = 1'b0;
        run_len(1'b1, n); run_len(1'b0, n); run_len(1'b1, n);
        for (int i = 0; i < 10; i++) begin
            run_len(1'b0, n); run_len(1'b1, n);
        end
        run_len(1'b0, n);
        repeat (10) @(negedge clk);
        host_drive = 1'b1;
        n_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (err === 1'b1) n_err++;
            if (i == 3) host_drive = 1'b0;
        end
        n_checks++;
        if (cap_to || n_err != 1)
            $display("FAIL bit_contention_err: got timeout %b err pulses %0d want 0 1", cap_to, n_err);
        else n_pass++;
        n_checks++;
        if ({busy, state_dbg, dht11_io} !== 5'b00001)
            $display("FAIL bit_contention_release: got %b want 00001", {busy, state_dbg, dht11_io});
        else n_pass++;
        test_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), T_START + 50, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        host_start(T_START + 50);
        cap_to = 1'b0;
        run_len(1'b1, n); run_len(1'b0, n); run_len(1'b1, n);
        for (int i = 0; i < 3; i++) begin
            run_len(1'b0, n); run_len(1'b1, n);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (cap_to || dht11_io !== 1'b0 || busy !== 1'b1)
            $display("FAIL pre_reset_bit_lo: got timeout %b line %b busy %b want 0 0 1", cap_to, dht11_io, busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, frame_done, err, state_dbg, dht11_io} !== 7'b0000001)
            $display("FAIL reset_mid_frame: got %b want 0000001", {busy, frame_done, err, state_dbg, dht11_io});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        test_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), T_START + 20, 1'b0);
        test_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), T_START + 20, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame(8'h37, 8'h00, 8'h19, 8'h05, 250, 1'b0);
        n_checks++;
        if (cap_frame[7:0] !== 8'h55) $display("FAIL basic_chk: got %h want 55", cap_frame[7:0]);
        else n_pass++;
        test_short_start();
        test_all_ones();
        // Input bytes change after the start is qualified; the latched frame must go out.
        test_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), T_START + 30, 1'b1);
        test_contention();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
